// File: rtl/ps2_keyboard_sender.sv
// ----------------------------------------------------------------------------
// ps2_keyboard_sender
//
// Device-side PS/2 keyboard emulator. Accepts ASCII key events (press or
// release), maps them to PS/2 Set-2 make/break byte sequences, and adds the
// Shift prefix/suffix for uppercase letters. Each byte goes out as an 11-bit
// frame (start, 8 data bits LSB first, odd parity, stop) on self-generated
// ps2_clk/ps2_data lines. Consecutive frames are separated by an idle gap.
//
// Parameters:
//   CLK_DIV     system cycles per ps2_clk half-period (>= 2)
//   GAP_CYCLES  idle cycles with both lines high between frames (>= 1)
//
// Ports:
//   clk              system clock
//   rst              synchronous reset, active-high
//   key_valid        key event offered
//   key_ascii        ASCII code of the offered event
//   key_release      1 = release (break), 0 = press (make)
//   key_ready        event accepted on a cycle with key_valid && key_ready
//   busy             a byte sequence is in progress (= !key_ready)
//   err_unsupported  one-cycle pulse after accepting an unmapped ASCII code
//   ps2_clk          PS/2 clock, idle high
//   ps2_data         PS/2 data, idle high
//   byte_cnt         completed frames, wraps 0xFF -> 0x00
// ----------------------------------------------------------------------------
module ps2_keyboard_sender #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [7:0] key_ascii,
    input  logic       key_release,
    output logic       key_ready,
    output logic       busy,
    output logic       err_unsupported,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic [7:0] byte_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_BIT,
        S_GAP
    } state_t;

    typedef struct packed {
        logic       ok;
        logic       upper;
        logic [7:0] code;
    } key_map_t;

    localparam int BIT_CYCLES = 2 * CLK_DIV;
    localparam int CNT_MAX    = (BIT_CYCLES > GAP_CYCLES) ? BIT_CYCLES : GAP_CYCLES;
    localparam int CW         = $clog2(CNT_MAX + 1);

    // ASCII to Set-2 make code. Uppercase letters reuse the lowercase code
    // and are flagged so the sequence gets wrapped in Shift.
    function automatic key_map_t map_key(input logic [7:0] ascii);
        key_map_t   m;
        logic [7:0] folded;
        m      = '{ok: 1'b1, upper: 1'b0, code: 8'h00};
        folded = ascii;
        if (ascii >= 8'h41 && ascii <= 8'h5A) begin
            m.upper = 1'b1;
            folded  = ascii | 8'h20;
        end
        case (folded)
            8'h31: m.code = 8'h16;  8'h32: m.code = 8'h1E;  8'h33: m.code = 8'h26;
            8'h34: m.code = 8'h25;  8'h35: m.code = 8'h2E;  8'h36: m.code = 8'h36;
            8'h37: m.code = 8'h3D;  8'h38: m.code = 8'h3E;  8'h39: m.code = 8'h46;
            8'h30: m.code = 8'h45;
            8'h61: m.code = 8'h1C;  8'h62: m.code = 8'h32;  8'h63: m.code = 8'h21;
            8'h64: m.code = 8'h23;  8'h65: m.code = 8'h24;  8'h66: m.code = 8'h2B;
            8'h67: m.code = 8'h34;  8'h68: m.code = 8'h33;  8'h69: m.code = 8'h43;
            8'h6A: m.code = 8'h3B;  8'h6B: m.code = 8'h42;  8'h6C: m.code = 8'h4B;
            8'h6D: m.code = 8'h3A;  8'h6E: m.code = 8'h31;  8'h6F: m.code = 8'h44;
            8'h70: m.code = 8'h4D;  8'h71: m.code = 8'h15;  8'h72: m.code = 8'h2D;
            8'h73: m.code = 8'h1B;  8'h74: m.code = 8'h2C;  8'h75: m.code = 8'h3C;
            8'h76: m.code = 8'h2A;  8'h77: m.code = 8'h1D;  8'h78: m.code = 8'h22;
            8'h79: m.code = 8'h35;  8'h7A: m.code = 8'h1A;
            default: begin
                m.ok    = 1'b0;
                m.upper = 1'b0;
            end
        endcase
        return m;
    endfunction

    state_t        state;
    state_t        state_next;
    key_map_t      key_map;
    logic          accept;
    logic [CW-1:0] cnt;          // bit-period or gap cycle counter
    logic [3:0]    bit_idx;      // 0 = start ... 10 = stop
    logic [10:0]   frame;        // frame[0] is the bit currently on ps2_data
    logic [7:0]    seq [4];      // byte sequence of the accepted event
    logic [1:0]    seq_idx;
    logic [1:0]    seq_last;     // index of the final byte in seq
    logic [7:0]    cur_byte;
    logic          bit_end;
    logic          frame_done;
    logic          gap_end;
    logic          last_byte;

    assign key_map    = map_key(key_ascii);
    assign accept     = (state == S_IDLE) && key_valid && key_map.ok;
    assign cur_byte   = seq[seq_idx];
    assign bit_end    = (cnt == CW'(BIT_CYCLES - 1));
    assign frame_done = (state == S_BIT) && bit_end && (bit_idx == 4'd10);
    assign gap_end    = (cnt == CW'(GAP_CYCLES - 1));
    assign last_byte  = (seq_idx == seq_last);
    assign busy       = ~key_ready;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case can leave a latch behind.
        state_next = state;
        key_ready  = 1'b0;
        ps2_clk    = 1'b1;
        ps2_data   = 1'b1;
        case (state)
            S_IDLE: begin
                key_ready = 1'b1;
                if (accept) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                state_next = S_BIT;
            end
            S_BIT: begin
                // High phase first, so data settles before the falling edge.
                ps2_clk  = (cnt < CW'(CLK_DIV));
                ps2_data = frame[0];
                if (frame_done) begin
                    state_next = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_end) begin
                    state_next = last_byte ? S_IDLE : S_LOAD;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt             <= '0;
            bit_idx         <= '0;
            frame           <= '1;
            seq_idx         <= '0;
            seq_last        <= '0;
            byte_cnt        <= '0;
            err_unsupported <= 1'b0;
        end else begin
            // Unmapped codes still complete the handshake; only flag them.
            err_unsupported <= (state == S_IDLE) && key_valid && !key_map.ok;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        seq_idx  <= '0;
                        seq_last <= {key_release & key_map.upper, key_release | key_map.upper};
                    end
                end
                S_LOAD: begin
                    frame   <= {1'b1, ~^cur_byte, cur_byte, 1'b0};
                    cnt     <= '0;
                    bit_idx <= '0;
                end
                S_BIT: begin
                    if (bit_end) begin
                        cnt     <= '0;
                        bit_idx <= bit_idx + 4'd1;
                        frame   <= {1'b1, frame[10:1]};
                        if (bit_idx == 4'd10) begin
                            byte_cnt <= byte_cnt + 8'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_end) begin
                        cnt     <= '0;
                        seq_idx <= seq_idx + 2'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // NOTE: the sequence buffer has no reset; it is always rewritten on
    // acceptance before LOAD reads any entry.
    always_ff @(posedge clk) begin
        if (accept) begin
            case ({key_release, key_map.upper})
                2'b00: begin
                    seq[0] <= key_map.code;
                end
                2'b01: begin
                    seq[0] <= 8'h12;
                    seq[1] <= key_map.code;
                end
                2'b10: begin
                    seq[0] <= 8'hF0;
                    seq[1] <= key_map.code;
                end
                default: begin
                    seq[0] <= 8'hF0;
                    seq[1] <= key_map.code;
                    seq[2] <= 8'hF0;
                    seq[3] <= 8'h12;
                end
            endcase
        end
    end

endmodule
